id_ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller that drives the write-enable and bubble-insert controls of the PC, the IF/ID register and the ID/EX register.
- Detects load-use hazards between the instruction in ID and a load in EX, and inserts one bubble.
- Freezes the front end while a multi-cycle multiply/divide occupies EX.
- Flushes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Keeps saturating stall and flush performance counters.

---
 rtl/id_ex_hazard_ctrl_if.sv | 37 +++
 rtl/id_ex_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the hazard controller (slave).
interface id_ex_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    // ID / EX stage information supplied by the datapath
    logic [4:0]           rsId;
    logic [4:0]           rtId;
    logic                 useRsId;
    logic                 useRtId;
    logic [4:0]           rWEx;
    logic                 memReadEx;
    logic                 mdStartEx;
    logic                 branchTakenEx;

    // Pipeline register controls returned by the controller
    logic                 pcWrite;
    logic                 ifIdWrite;
    logic                 ifIdFlush;
    logic                 idExWrite;
    logic                 idExFlush;
    logic                 mdBusy;
    logic                 mdDone;
    logic [CNT_WIDTH-1:0] stallCount;
    logic [CNT_WIDTH-1:0] flushCount;

    modport master (
        output rsId, rtId, useRsId, useRtId, rWEx, memReadEx, mdStartEx, branchTakenEx,
        input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, mdBusy, mdDone,
        input  stallCount, flushCount
    );

    modport slave (
        input  rsId, rtId, useRsId, useRtId, rWEx, memReadEx, mdStartEx, branchTakenEx,
        output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, mdBusy, mdDone,
        output stallCount, flushCount
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use bubble, mul/div front-end freeze, branch flush,
// and saturating stall/flush performance counters. Outputs are combinational.
module id_ex_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               reset,
    id_ex_hazard_ctrl_if.slave bus
);
    localparam int unsigned MdCntW = $clog2(MD_LATENCY);

    typedef enum logic [0:0] {StRun, StMdBusy} state_e;

    state_e               state_q, state_d;
    logic [MdCntW-1:0]    md_cnt_q, md_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                 stall_inc, flush_inc;
    logic                 load_use;

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, md_busy, md_done;

    // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = bus.memReadEx && (bus.rWEx != 5'd0) &&
                      ((bus.useRsId && (bus.rsId == bus.rWEx)) ||
                       (bus.useRtId && (bus.rtId == bus.rWEx)));

    // Next-state, counter-increment and pipeline-control decode.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_write = 1'b1;
        id_ex_flush = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            // Flush both pipeline registers while reset is held.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = StRun;
            md_cnt_d    = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.branchTakenEx) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (bus.mdStartEx) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        state_d     = StMdBusy;
                        md_cnt_d    = MdCntW'(MD_LATENCY - 1);
                        stall_inc   = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, push one bubble into ID/EX.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
                StMdBusy: begin
                    // EX holds the mul/div, so branch and load-use inputs are meaningless here.
                    md_busy = 1'b1;
                    if (md_cnt_q > MdCntW'(1)) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        md_cnt_d    = md_cnt_q - MdCntW'(1);
                        stall_inc   = 1'b1;
                    end else begin
                        md_done  = 1'b1;
                        state_d  = StRun;
                        md_cnt_d = '0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // State, mul/div countdown and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pcWrite    = pc_write;
    assign bus.ifIdWrite  = if_id_write;
    assign bus.ifIdFlush  = if_id_flush;
    assign bus.idExWrite  = id_ex_write;
    assign bus.idExFlush  = id_ex_flush;
    assign bus.mdBusy     = md_busy;
    assign bus.mdDone     = md_done;
    assign bus.stallCount = stall_cnt_q;
    assign bus.flushCount = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: a default instance plus a CNT_WIDTH=4 instance
// used for counter saturation.
module tb_id_ex_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl_if #(.CNT_WIDTH(16)) bus ();
    id_ex_hazard_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

    id_ex_hazard_ctrl #(.MD_LATENCY(4), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    id_ex_hazard_ctrl #(.MD_LATENCY(4), .CNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, mdBusy, mdDone}
    logic [6:0] ctl, ctl4;
    assign ctl  = {bus.pcWrite, bus.ifIdWrite, bus.ifIdFlush, bus.idExWrite, bus.idExFlush,
                   bus.mdBusy, bus.mdDone};
    assign ctl4 = {bus4.pcWrite, bus4.ifIdWrite, bus4.ifIdFlush, bus4.idExWrite, bus4.idExFlush,
                   bus4.mdBusy, bus4.mdDone};

    localparam logic [6:0] CtlRst    = 7'b1111100;
    localparam logic [6:0] CtlNormal = 7'b1101000;
    localparam logic [6:0] CtlBubble = 7'b0001100;
    localparam logic [6:0] CtlFlush  = 7'b1111100;
    localparam logic [6:0] CtlFrz0   = 7'b0000000;
    localparam logic [6:0] CtlFrzBsy = 7'b0000010;
    localparam logic [6:0] CtlRel    = 7'b1101011;

    task automatic idle();
        bus.rsId = 5'd0;  bus.rtId = 5'd0;  bus.useRsId = 1'b0; bus.useRtId = 1'b0;
        bus.rWEx = 5'd0;  bus.memReadEx = 1'b0; bus.mdStartEx = 1'b0; bus.branchTakenEx = 1'b0;
    endtask

    task automatic idle4();
        bus4.rsId = 5'd0; bus4.rtId = 5'd0; bus4.useRsId = 1'b0; bus4.useRtId = 1'b0;
        bus4.rWEx = 5'd0; bus4.memReadEx = 1'b0; bus4.mdStartEx = 1'b0;
        bus4.branchTakenEx = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        idle4();
        step();
        step();
        #1;
        n_vec++;
        if (ctl !== CtlRst) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CtlRst);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL idle_ctl: got %b want %b", ctl, CtlNormal);
        end
        step();
        n_vec++;
        if (bus.stallCount !== 16'd0 || bus.flushCount !== 16'd0) begin
            n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0",
                              bus.stallCount, bus.flushCount);
        end
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        // rt match on a load -> one bubble
        bus.memReadEx = 1'b1; bus.rWEx = 5'd5; bus.rtId = 5'd5; bus.useRtId = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlBubble) begin
            n_err++; $display("FAIL loaduse_rt: got %b want %b", ctl, CtlBubble);
        end
        step();
        exp_stall++;
        idle();
        #1;
        n_vec++;
        if (ctl !== CtlNormal || bus.stallCount !== 16'(exp_stall)) begin
            n_err++; $display("FAIL loaduse_clear: got %b/%0d want %b/%0d",
                              ctl, bus.stallCount, CtlNormal, exp_stall);
        end
        // rWEx = 0 never hazards
        bus.memReadEx = 1'b1; bus.rWEx = 5'd0; bus.rtId = 5'd0; bus.useRtId = 1'b1;
        bus.rsId = 5'd0; bus.useRsId = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL loaduse_r0: got %b want %b", ctl, CtlNormal);
        end
        // rs match
        bus.rWEx = 5'd7; bus.rsId = 5'd7; bus.rtId = 5'd3;
        #1;
        n_vec++;
        if (ctl !== CtlBubble) begin
            n_err++; $display("FAIL loaduse_rs: got %b want %b", ctl, CtlBubble);
        end
        // matching field not read
        bus.useRsId = 1'b0; bus.useRtId = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL loaduse_unused: got %b want %b", ctl, CtlNormal);
        end
        // match but not a load
        bus.useRsId = 1'b1; bus.memReadEx = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL loaduse_noload: got %b want %b", ctl, CtlNormal);
        end
        step();
        idle();
        #1;
        n_vec++;
        if (bus.stallCount !== 16'(exp_stall)) begin
            n_err++; $display("FAIL loaduse_count: got %0d want %0d", bus.stallCount, exp_stall);
        end
    endtask

    task automatic test_muldiv();
        logic [6:0] exp_ctl [4];
        exp_ctl[0] = CtlFrz0;
        exp_ctl[1] = CtlFrzBsy;
        exp_ctl[2] = CtlFrzBsy;
        exp_ctl[3] = CtlRel;
        for (int c = 0; c < 4; c++) begin
            idle();
            bus.mdStartEx = 1'b1;
            // Branch and load-use inputs while busy must be ignored.
            if (c == 2) bus.branchTakenEx = 1'b1;
            if (c == 3) begin
                bus.memReadEx = 1'b1; bus.rWEx = 5'd9; bus.rsId = 5'd9; bus.useRsId = 1'b1;
            end
            #1;
            n_vec++;
            if (ctl !== exp_ctl[c]) begin
                n_err++; $display("FAIL md_cycle%0d: got %b want %b", c, ctl, exp_ctl[c]);
            end
            step();
            if (c < 3) exp_stall++;
        end
        idle();
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL md_after: got %b want %b", ctl, CtlNormal);
        end
        n_vec++;
        if (bus.stallCount !== 16'(exp_stall) || bus.flushCount !== 16'(exp_flush)) begin
            n_err++; $display("FAIL md_counts: got %0d/%0d want %0d/%0d",
                              bus.stallCount, bus.flushCount, exp_stall, exp_flush);
        end
    endtask

    task automatic test_branch_priority();
        bus.branchTakenEx = 1'b1; bus.mdStartEx = 1'b1;
        bus.memReadEx = 1'b1; bus.rWEx = 5'd12; bus.rtId = 5'd12; bus.useRtId = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlFlush) begin
            n_err++; $display("FAIL branch_ctl: got %b want %b", ctl, CtlFlush);
        end
        step();
        exp_flush++;
        idle();
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL branch_no_md: got %b want %b", ctl, CtlNormal);
        end
        n_vec++;
        if (bus.flushCount !== 16'(exp_flush) || bus.stallCount !== 16'(exp_stall)) begin
            n_err++; $display("FAIL branch_counts: got %0d/%0d want %0d/%0d",
                              bus.flushCount, bus.stallCount, exp_flush, exp_stall);
        end
    endtask

    task automatic test_reset_in_md();
        bus.mdStartEx = 1'b1;
        step();
        step();
        // second MD_BUSY cycle
        reset = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlRst) begin
            n_err++; $display("FAIL rstmd_during: got %b want %b", ctl, CtlRst);
        end
        step();
        reset = 1'b0;
        idle();
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL rstmd_after: got %b want %b", ctl, CtlNormal);
        end
        exp_stall = 0;
        exp_flush = 0;
        n_vec++;
        if (bus.stallCount !== 16'd0 || bus.flushCount !== 16'd0) begin
            n_err++; $display("FAIL rstmd_counts: got %0d/%0d want 0/0",
                              bus.stallCount, bus.flushCount);
        end
        step();
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_err++; $display("FAIL rstmd_next: got %b want %b", ctl, CtlNormal);
        end
    endtask

    task automatic test_saturation();
        int e;
        n_vec++;
        if (bus4.stallCount !== 4'd0) begin
            n_err++; $display("FAIL sat_start: got %0d want 0", bus4.stallCount);
        end
        bus4.memReadEx = 1'b1; bus4.rWEx = 5'd20; bus4.rtId = 5'd20; bus4.useRtId = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_vec++;
            if (ctl4 !== CtlBubble) begin
                n_err++; $display("FAIL sat_ctl%0d: got %b want %b", i, ctl4, CtlBubble);
            end
            step();
            e = (i + 1 > 15) ? 15 : i + 1;
            n_vec++;
            if (bus4.stallCount !== 4'(e)) begin
                n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, bus4.stallCount, e);
            end
        end
        idle4();
        n_vec++;
        if (bus4.flushCount !== 4'd0) begin
            n_err++; $display("FAIL sat_flush: got %0d want 0", bus4.flushCount);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch_priority();
        test_reset_in_md();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
